// File: rtl/arbiter_grant_lock_pkg.sv
// Shared types and helpers for the grant-lock arbiter.
// Holds the FSM state encoding and the requester count.
package arbiter_grant_lock_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [1:0] onehot_to_idx(
        input logic [NUM_REQ-1:0] oh
    );
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_grant_lock_pick.sv
// Combinational fixed-priority picker.
// Bit 0 wins; output is one-hot or all zeros.
import arbiter_grant_lock_pkg::*;

module fixed_priority_pick (
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_pick
);

    // Isolate the lowest set bit.
    assign o_pick = i_req & (~i_req + NUM_REQ'(1));

endmodule

// File: rtl/arbiter_grant_lock.sv
// Four-way fixed-priority arbiter with grant lock, burst limit
// and a one-shot mask on the requester whose burst expired.
import arbiter_grant_lock_pkg::*;

module arbiter_grant_lock #(
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                done,
    output logic [NUM_REQ-1:0]  grant,
    output logic [1:0]          grant_id,
    output logic                grant_valid,
    output logic                timeout
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [1:0]          r_grant_id;
    logic                r_grant_valid;
    logic                r_timeout;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_mask;

    logic [NUM_REQ-1:0]  w_masked_req;
    logic [NUM_REQ-1:0]  w_pick;
    logic                w_owner_req;
    logic                w_at_limit;
    logic                w_release;
    logic                w_expired;

    assign w_masked_req = req & ~r_mask;

    fixed_priority_pick u_pick (
        .i_req  (w_masked_req),
        .o_pick (w_pick)
    );

    assign w_owner_req = |(req & r_grant);
    assign w_at_limit  = (r_cnt == CNT_MAX);
    assign w_release   = done | ~w_owner_req | w_at_limit;
    // Only a pure burst expiry counts as a timeout.
    assign w_expired   = w_at_limit & ~done & w_owner_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_cnt         <= '0;
            r_mask        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    r_mask    <= '0;
                    if (|w_pick) begin
                        r_state       <= BUSY;
                        r_grant       <= w_pick;
                        r_grant_id    <= onehot_to_idx(w_pick);
                        r_grant_valid <= 1'b1;
                        r_cnt         <= CW'(1);
                    end else begin
                        r_grant       <= '0;
                        r_grant_id    <= '0;
                        r_grant_valid <= 1'b0;
                        r_cnt         <= '0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_state       <= IDLE;
                        r_grant       <= '0;
                        r_grant_id    <= '0;
                        r_grant_valid <= 1'b0;
                        r_cnt         <= '0;
                        r_timeout     <= w_expired;
                        r_mask        <= w_expired ? r_grant : '0;
                    end else begin
                        r_cnt         <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_arbiter_grant_lock.sv
// Directed bench for arbiter_grant_lock with MAX_BURST = 8.
// Inputs change and outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_arbiter_grant_lock;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_chk;
    int n_fail;

    arbiter_grant_lock #(.MAX_BURST(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g,
                           input logic [1:0] id, input logic v,
                           input logic to);
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".id"}, {2'b00, grant_id}, {2'b00, id});
        chk({tag, ".valid"}, {3'b000, grant_valid}, {3'b000, v});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, to});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Quiet after reset
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("quiet", 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Burst expiry and mask
        req = 4'b0110;
        tick();
        chk_all("burst.first", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all("burst.hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        chk_all("burst.timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_all("burst.masked", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_all("burst.drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("burst.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // No preemption, then done
        req = 4'b1000;
        tick();
        chk_all("nopre.grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        req = 4'b1001;
        tick();
        chk_all("nopre.hold1", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        chk_all("nopre.hold2", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_all("nopre.done", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk_all("nopre.next", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Owner drops its request
        req = 4'b1100;
        tick();
        chk_all("drop.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("drop.next", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        chk_all("drop.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done coinciding with the limit: normal release
        req = 4'b0001;
        tick();
        chk_all("lim.grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk_all("lim.eighth", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_all("lim.release", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk_all("lim.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Lone masked requester: one extra idle cycle
        for (int i = 0; i < 7; i++) tick();
        tick();
        chk_all("lone.timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_all("lone.clear", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("lone.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Reset mid-burst
        req = 4'b1111;
        tick();
        chk_all("rst.busy", 4'b0001, 2'd0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("rst.drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("rst.first", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
